// File: rtl/priv_1_11_trap_sequencer_if.sv
// Purpose : pipeline-side inputs and CSR-update outputs of the M-mode trap sequencer.
// Latency : n/a (wires only).
// Backpressure: none; the sequencer holds traps internally until pipe_clear.
//
// Modports: master = the sequencer (reads trap sources, drives CSR update and intr);
//           slave  = the surrounding pipeline/CSR file (the reverse view).
// Optional feature macro: PRIV_RMGMT_EXC_EN adds the NUM_EXTENSIONS parameter and
// the ex_rmgmt / ex_rmgmt_cause signals for RISC-MGMT custom exceptions.
interface priv_1_11_trap_sequencer_if
`ifdef PRIV_RMGMT_EXC_EN
    #(parameter int NUM_EXTENSIONS = 1)
`endif
    ;

`ifdef PRIV_RMGMT_EXC_EN
    // A single extension still needs one bit to carry its (zero) index.
    localparam int RMGMT_W = (NUM_EXTENSIONS > 1) ? $clog2(NUM_EXTENSIONS) : 1;
    logic               ex_rmgmt;
    logic [RMGMT_W-1:0] ex_rmgmt_cause;
`endif

    logic [8:0]  sync_exc;
    logic [2:0]  irq_pend;
    logic [2:0]  irq_en;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] epc;
    logic [31:0] mtval;
    logic        pipe_clear;
    logic        ret;

    logic        intr;
    logic        mcause_rup;
    logic [31:0] mcause_next;
    logic        mepc_rup;
    logic [31:0] mepc_next;
    logic        mtval_rup;
    logic [31:0] mtval_next;
    logic        mstatus_rup;
    logic        mie_next;
    logic        mpie_next;

    modport master (
`ifdef PRIV_RMGMT_EXC_EN
        input  ex_rmgmt, ex_rmgmt_cause,
`endif
        input  sync_exc, irq_pend, irq_en, mstatus_mie, mstatus_mpie,
        input  epc, mtval, pipe_clear, ret,
        output intr, mcause_rup, mcause_next, mepc_rup, mepc_next,
        output mtval_rup, mtval_next, mstatus_rup, mie_next, mpie_next
    );

    modport slave (
`ifdef PRIV_RMGMT_EXC_EN
        output ex_rmgmt, ex_rmgmt_cause,
`endif
        output sync_exc, irq_pend, irq_en, mstatus_mie, mstatus_mpie,
        output epc, mtval, pipe_clear, ret,
        input  intr, mcause_rup, mcause_next, mepc_rup, mepc_next,
        input  mtval_rup, mtval_next, mstatus_rup, mie_next, mpie_next
    );

endinterface

// File: rtl/priv_1_11_trap_sequencer.sv
// Purpose : M-mode trap/MRET sequencer; prioritises exceptions over interrupts, emits CSR update strobes.
// Latency : trap detect -> COMMIT strobes 2 cycles minimum; MRET -> mstatus strobe next cycle.
// Backpressure: a captured trap waits in PEND until pipe_clear; new events and ret are ignored meanwhile.
//
// Ports: CLK, nRST (async active-low); bus = priv_1_11_trap_sequencer_if.master carrying
//        sync_exc/irq_pend/irq_en/mstatus fields/epc/mtval/pipe_clear/ret in, and
//        intr plus the mcause/mepc/mtval/mstatus update strobes and next-values out.
// Optional feature macro: PRIV_RMGMT_EXC_EN (RISC-MGMT custom exception, causes 24..31).
module priv_1_11_trap_sequencer (
    input  logic                               CLK,
    input  logic                               nRST,
    priv_1_11_trap_sequencer_if.master         bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        COMMIT = 2'd2,
        RETC   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  irq_elig;
    logic        exc_any;
    logic        trap_det;
    logic [31:0] cause_d;
    logic [31:0] tval_d;

    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] tval_q;
    logic        cap_mie_q;   // mstatus.MIE at trap capture, becomes MPIE on commit
    logic        ret_mpie_q;  // mstatus.MPIE at MRET, becomes MIE in RETC

    // Trap source selection. The if-chain order is the architectural priority:
    // synchronous exceptions first (bit order of sync_exc), then interrupts.
    always_comb begin
        irq_elig = bus.irq_pend & bus.irq_en & {3{bus.mstatus_mie}};
        exc_any  = |bus.sync_exc;
`ifdef PRIV_RMGMT_EXC_EN
        exc_any  = exc_any | bus.ex_rmgmt;
`endif
        cause_d  = 32'd0;
        tval_d   = 32'd0;
        if (bus.sync_exc[0]) begin          // fault_insn
            cause_d = 32'd1;
            tval_d  = bus.mtval;
        end else if (bus.sync_exc[1]) begin // mal_insn
            cause_d = 32'd0;
            tval_d  = bus.mtval;
        end else if (bus.sync_exc[2]) begin // illegal_insn
            cause_d = 32'd2;
            tval_d  = bus.mtval;
        end else if (bus.sync_exc[3]) begin // breakpoint, tval stays 0
            cause_d = 32'd3;
        end else if (bus.sync_exc[4]) begin // env_m, tval stays 0
            cause_d = 32'd11;
        end else if (bus.sync_exc[5]) begin // mal_s
            cause_d = 32'd6;
            tval_d  = bus.mtval;
        end else if (bus.sync_exc[6]) begin // mal_l
            cause_d = 32'd4;
            tval_d  = bus.mtval;
        end else if (bus.sync_exc[7]) begin // fault_s
            cause_d = 32'd7;
            tval_d  = bus.mtval;
        end else if (bus.sync_exc[8]) begin // fault_l
            cause_d = 32'd5;
            tval_d  = bus.mtval;
`ifdef PRIV_RMGMT_EXC_EN
        end else if (bus.ex_rmgmt) begin
            // Custom range starts at 24; at most 8 extensions keep it inside [4:0].
            cause_d = 32'd24 + 32'(bus.ex_rmgmt_cause);
            tval_d  = bus.mtval;
`endif
        end else if (irq_elig[2]) begin     // external
            cause_d = 32'h8000_000B;
        end else if (irq_elig[1]) begin     // software
            cause_d = 32'h8000_0003;
        end else if (irq_elig[0]) begin     // timer
            cause_d = 32'h8000_0007;
        end
        trap_det = exc_any | (|irq_elig);
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A trap in IDLE outranks a simultaneous ret, which is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (trap_det) begin
                    state_d = PEND;
                end else if (bus.ret) begin
                    state_d = RETC;
                end
            end
            PEND: begin
                if (bus.pipe_clear) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            RETC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture registers: only loaded in IDLE, so next-values stay frozen
    // from PEND entry through COMMIT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            tval_q     <= 32'd0;
            cap_mie_q  <= 1'b0;
            ret_mpie_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (trap_det) begin
                cause_q   <= cause_d;
                epc_q     <= bus.epc;
                tval_q    <= tval_d;
                cap_mie_q <= bus.mstatus_mie;
            end else if (bus.ret) begin
                ret_mpie_q <= bus.mstatus_mpie;
            end
        end
    end

    // Output decode: strobes are pure functions of the registered state, so
    // reset removes them immediately and they are always exactly one cycle wide.
    always_comb begin
        bus.intr        = 1'b0;
        bus.mcause_rup  = 1'b0;
        bus.mepc_rup    = 1'b0;
        bus.mtval_rup   = 1'b0;
        bus.mstatus_rup = 1'b0;
        bus.mie_next    = 1'b0;
        bus.mpie_next   = 1'b0;
        bus.mcause_next = cause_q;
        bus.mepc_next   = epc_q;
        bus.mtval_next  = tval_q;
        case (state_q)
            PEND: begin
                bus.intr = 1'b1;
            end
            COMMIT: begin
                bus.intr        = 1'b1;
                bus.mcause_rup  = 1'b1;
                bus.mepc_rup    = 1'b1;
                bus.mtval_rup   = 1'b1;
                bus.mstatus_rup = 1'b1;
                bus.mie_next    = 1'b0;
                bus.mpie_next   = cap_mie_q;
            end
            RETC: begin
                bus.mstatus_rup = 1'b1;
                bus.mie_next    = ret_mpie_q;
                bus.mpie_next   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_priv_1_11_trap_sequencer.sv
// Purpose : self-checking bench for priv_1_11_trap_sequencer (directed cases + random traffic).
// Latency : each step is one clock; outputs are sampled 1 time unit after the rising edge.
// Backpressure: pipe_clear is driven by the bench to stretch or shorten the drain wait.
module tb_priv_1_11_trap_sequencer;

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    always #5 CLK = ~CLK;

`ifdef PRIV_RMGMT_EXC_EN
    priv_1_11_trap_sequencer_if #(.NUM_EXTENSIONS(4)) bus ();
`else
    priv_1_11_trap_sequencer_if bus ();
`endif

    priv_1_11_trap_sequencer dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Architectural tables: sync_exc bit i -> cause code, and whether it reports mtval.
    localparam int       EXC_CODE [9] = '{1, 0, 2, 3, 11, 6, 4, 7, 5};
    localparam bit [8:0] EXC_TVAL     = 9'b1_1110_0111;
    // Interrupts in priority order: mip bit and cause code.
    localparam int       IRQ_BIT  [3] = '{2, 1, 0};
    localparam int       IRQ_CODE [3] = '{11, 3, 7};

    // Reference model: what the trap unit is busy with, and the last captured record.
    bit          m_pend, m_commit, m_retc;
    logic [31:0] m_cause, m_epc, m_tval;
    bit          m_trap_mie, m_ret_mie;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_commit = 0; m_retc = 0;
        m_cause = 0; m_epc = 0; m_tval = 0;
        m_trap_mie = 0; m_ret_mie = 0;
    endtask

    task automatic ref_trap(output bit hit, output logic [31:0] cause, output logic [31:0] tval);
        hit = 0; cause = 0; tval = 0;
        for (int i = 0; i < 9; i++) begin
            if (!hit && bus.sync_exc[i]) begin
                hit   = 1;
                cause = 32'(EXC_CODE[i]);
                tval  = EXC_TVAL[i] ? bus.mtval : 32'd0;
            end
        end
`ifdef PRIV_RMGMT_EXC_EN
        if (!hit && bus.ex_rmgmt) begin
            hit   = 1;
            cause = 32'(24 + int'(bus.ex_rmgmt_cause));
            tval  = bus.mtval;
        end
`endif
        for (int k = 0; k < 3; k++) begin
            if (!hit && bus.mstatus_mie && bus.irq_en[IRQ_BIT[k]] && bus.irq_pend[IRQ_BIT[k]]) begin
                hit   = 1;
                cause = 32'h8000_0000 | 32'(IRQ_CODE[k]);
            end
        end
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit          hit;
        logic [31:0] c, t;
        if (!nRST) begin
            model_reset();
            return;
        end
        ref_trap(hit, c, t);
        if (m_pend) begin
            if (bus.pipe_clear) begin
                m_pend = 0; m_commit = 1;
            end
        end else if (m_commit || m_retc) begin
            m_commit = 0; m_retc = 0;
        end else if (hit) begin
            m_pend = 1; m_cause = c; m_epc = bus.epc; m_tval = t;
            m_trap_mie = bus.mstatus_mie;
        end else if (bus.ret) begin
            m_retc = 1; m_ret_mie = bus.mstatus_mpie;
        end
    endtask

    task automatic cmp_all();
        chk("intr", 32'(bus.intr), 32'(m_pend | m_commit));
        chk("strobes", {28'd0, bus.mcause_rup, bus.mepc_rup, bus.mtval_rup, bus.mstatus_rup},
            {28'd0, m_commit, m_commit, m_commit, m_commit | m_retc});
        chk("mcause_next", bus.mcause_next, m_cause);
        chk("mepc_next", bus.mepc_next, m_epc);
        chk("mtval_next", bus.mtval_next, m_tval);
        chk("mie_mpie", {30'd0, bus.mie_next, bus.mpie_next},
            {30'd0, m_retc & m_ret_mie, (m_commit & m_trap_mie) | m_retc});
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        cmp_all();
    endtask

    task automatic quiet_inputs();
        bus.sync_exc = '0; bus.irq_pend = '0; bus.irq_en = '0;
        bus.mstatus_mie = 0; bus.mstatus_mpie = 0;
        bus.epc = '0; bus.mtval = '0; bus.pipe_clear = 0; bus.ret = 0;
`ifdef PRIV_RMGMT_EXC_EN
        bus.ex_rmgmt = 0; bus.ex_rmgmt_cause = '0;
`endif
    endtask

    function automatic logic [3:0] strobes();
        return {bus.mcause_rup, bus.mepc_rup, bus.mtval_rup, bus.mstatus_rup};
    endfunction

    initial begin
        quiet_inputs();
        model_reset();
        #1;
        cmp_all();
        chk("reset_intr", 32'(bus.intr), 32'd0);
        step();
        step();
        nRST = 1'b1;

        // Illegal instruction with a slow drain: intr for 4 cycles, COMMIT in the 4th.
        bus.mstatus_mie = 1; bus.sync_exc = 9'h004; bus.epc = 32'h100; bus.mtval = 32'hDEAD_BEEF;
        step();
        bus.sync_exc = '0;
        chk("t1_intr_T1", 32'(bus.intr), 32'd1);
        step();
        step();
        bus.pipe_clear = 1;
        step();
        chk("t1_strobes", 32'(strobes()), 32'hF);
        chk("t1_mcause", bus.mcause_next, 32'd2);
        chk("t1_mepc", bus.mepc_next, 32'h100);
        chk("t1_mtval", bus.mtval_next, 32'hDEAD_BEEF);
        chk("t1_mie_mpie", 32'({bus.mie_next, bus.mpie_next}), 32'b01);
        bus.pipe_clear = 0;
        step();
        chk("t1_idle_intr", 32'(bus.intr), 32'd0);

        // All sources at once, then interrupts alone.
        bus.sync_exc = 9'h1FF; bus.irq_pend = 3'b111; bus.irq_en = 3'b111; bus.pipe_clear = 1;
        step();
        bus.sync_exc = '0;
        step();
        chk("t2_sync_prio", bus.mcause_next, 32'd1);
        step();
        step();
        step();
        chk("t2_irq_prio", bus.mcause_next, 32'h8000_000B);
        chk("t2_irq_tval", bus.mtval_next, 32'd0);
        quiet_inputs();
        step();

        // Globally disabled interrupt never traps.
        bus.irq_pend = 3'b001; bus.irq_en = 3'b001;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_masked", {27'd0, bus.intr, strobes()}, 32'd0);
        end
        quiet_inputs();

        // MRET alone, then trap colliding with MRET.
        bus.mstatus_mpie = 1; bus.ret = 1;
        step();
        chk("t4_ret_strobes", 32'(strobes()), 32'b0001);
        chk("t4_ret_fields", 32'({bus.mie_next, bus.mpie_next}), 32'b11);
        bus.ret = 0;
        step();
        chk("t4_ret_once", 32'(strobes()), 32'd0);
        bus.mstatus_mie = 1; bus.sync_exc = 9'h008; bus.ret = 1; bus.epc = 32'h200; bus.mtval = 32'h55;
        step();
        chk("t4_collide_intr", 32'(bus.intr), 32'd1);
        quiet_inputs();
        bus.pipe_clear = 1;
        step();
        chk("t4_bkpt_cause", bus.mcause_next, 32'd3);
        chk("t4_bkpt_tval", bus.mtval_next, 32'd0);
        bus.pipe_clear = 0;
        step();
        step();
        chk("t4_ret_dropped", 32'(strobes()), 32'd0);

        // Reset while a trap is pending.
        bus.sync_exc = 9'h100; bus.epc = 32'h300;
        step();
        bus.sync_exc = '0;
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_now", {27'd0, bus.intr, strobes()}, 32'd0);
        cmp_all();
        bus.pipe_clear = 1;
        step();
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_commit", {27'd0, bus.intr, strobes()}, 32'd0);
        end
        quiet_inputs();

`ifdef PRIV_RMGMT_EXC_EN
        bus.ex_rmgmt = 1; bus.ex_rmgmt_cause = 2'd2; bus.pipe_clear = 1;
        step();
        bus.ex_rmgmt = 0;
        step();
        chk("t6_rmgmt_cause", bus.mcause_next, 32'd26);
        step();
        bus.ex_rmgmt = 1; bus.sync_exc = 9'h010;
        step();
        quiet_inputs();
        bus.pipe_clear = 1;
        step();
        chk("t6_envm_wins", bus.mcause_next, 32'd11);
        quiet_inputs();
        step();
`endif

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0)
                bus.sync_exc = 9'($urandom);
            else if ($urandom_range(0, 7) == 0)
                bus.sync_exc = 9'(32'd1 << $urandom_range(0, 8));
            else
                bus.sync_exc = '0;
            bus.irq_pend     = 3'($urandom);
            bus.irq_en       = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            bus.mstatus_mie  = 1'($urandom);
            bus.mstatus_mpie = 1'($urandom);
            bus.epc          = $urandom;
            bus.mtval        = $urandom;
            bus.pipe_clear   = 1'($urandom);
            bus.ret          = ($urandom_range(0, 4) == 0);
`ifdef PRIV_RMGMT_EXC_EN
            bus.ex_rmgmt       = ($urandom_range(0, 7) == 0);
            bus.ex_rmgmt_cause = 2'($urandom);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
